// File: rtl/rename_dispatch_ctrl.sv
// rename_dispatch_ctrl: admits decode pairs into rename when free registers and ROB space suffice, sequences the rename-table init sweep.
// Ports: clock/reset (sync, active-high); dec_v1/dec_dst1/dec_v2/dec_dst2 decode pair; dec_ready combinational accept;
// stall_in downstream stall; cmt_cnt/cmt_free commit accounting; flush restarts init; ren_v1/ren_v2 registered valids;
// stall_out resource hold; init_busy/init_idx sweep; free_cnt/rob_cnt counts; err sticky accounting error.
// Optional macro RENAME_DISPATCH_PERF_EN adds perf_stall, a saturating count of RUN cycles with a pair held.
module rename_dispatch_ctrl #(
  parameter int NUM_ARCH  = 7,
  parameter int NUM_PHYS  = 10,
  parameter int ROB_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dec_v1,
  input  logic [2:0] dec_dst1,
  input  logic       dec_v2,
  input  logic [2:0] dec_dst2,
  output logic       dec_ready,
  input  logic       stall_in,
  input  logic [1:0] cmt_cnt,
  input  logic [1:0] cmt_free,
  input  logic       flush,
  output logic       ren_v1,
  output logic       ren_v2,
  output logic       stall_out,
  output logic       init_busy,
  output logic [3:0] init_idx,
  output logic [3:0] free_cnt,
  output logic [4:0] rob_cnt,
`ifdef RENAME_DISPATCH_PERF_EN
  output logic [15:0] perf_stall,
`endif
  output logic       err
);
  localparam logic [3:0] FREE_MAX = 4'(NUM_PHYS - NUM_ARCH);
  localparam logic [3:0] IDX_LAST = 4'(NUM_PHYS);
  localparam logic [5:0] ROB_MAX  = 6'(ROB_DEPTH);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;
  logic [1:0] need, slots;
  logic       any_v, ok, fire, free_ovf, rob_unf;
  logic [5:0] rob_need;
  logic [3:0] free_sum;
  logic [4:0] rob_add;
  assign any_v     = dec_v1 || dec_v2;
  assign need      = {1'b0, dec_v1 && dec_dst1 != 3'd0} + {1'b0, dec_v2 && dec_dst2 != 3'd0};
  assign slots     = {1'b0, dec_v1} + {1'b0, dec_v2};
  assign rob_need  = {1'b0, rob_cnt} + {4'b0, slots};
  assign ok        = {2'b0, need} <= free_cnt && rob_need <= ROB_MAX;
  assign dec_ready = state == RUN && !stall_in && ok;
  assign fire      = dec_ready && any_v;
  assign init_busy = state == INIT;
  // fire guarantees need<=free_cnt, so free_sum cannot wrap below zero
  assign free_sum  = free_cnt + {2'b0, cmt_free} - (fire ? {2'b0, need} : 4'd0);
  assign free_ovf  = free_sum > FREE_MAX;
  // fire guarantees rob_cnt+slots<=ROB_DEPTH, so rob_add fits 5 bits
  assign rob_add   = rob_cnt + (fire ? {3'b0, slots} : 5'd0);
  assign rob_unf   = {3'b0, cmt_cnt} > rob_add;
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = INIT;
    else if (state == INIT && init_idx == IDX_LAST) state_nxt = RUN;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= INIT;
    else state <= state_nxt;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      init_idx  <= 4'd1;
      free_cnt  <= FREE_MAX;
      rob_cnt   <= 5'd0;
      ren_v1    <= 1'b0;
      ren_v2    <= 1'b0;
      stall_out <= 1'b0;
      err       <= 1'b0;
    end else if (flush) begin
      init_idx  <= 4'd1;
      free_cnt  <= FREE_MAX;
      rob_cnt   <= 5'd0;
      ren_v1    <= 1'b0;
      ren_v2    <= 1'b0;
      stall_out <= 1'b0;
    end else if (state == INIT) begin
      init_idx  <= init_idx == IDX_LAST ? init_idx : init_idx + 4'd1;
      ren_v1    <= 1'b0;
      ren_v2    <= 1'b0;
      stall_out <= 1'b0;
    end else begin
      ren_v1    <= fire && dec_v1;
      ren_v2    <= fire && dec_v2;
      stall_out <= any_v && !stall_in && !ok;
      free_cnt  <= free_ovf ? FREE_MAX : free_sum;
      rob_cnt   <= rob_unf ? 5'd0 : rob_add - {3'b0, cmt_cnt};
      err       <= err || free_ovf || rob_unf;
    end
  end
`ifdef RENAME_DISPATCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) perf_stall <= 16'd0;
    else if (state == RUN && any_v && !dec_ready && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
  end
`endif
endmodule

// File: tb/tb_rename_dispatch_ctrl.sv
// tb_rename_dispatch_ctrl: table vectors, corner sequences and random stimulus against a behavioural model.
module tb_rename_dispatch_ctrl;
  logic       clock = 0, reset = 1;
  logic       dec_v1 = 0, dec_v2 = 0, stall_in = 0, flush = 0;
  logic [2:0] dec_dst1 = 0, dec_dst2 = 0;
  logic [1:0] cmt_cnt = 0, cmt_free = 0;
  logic       dec_ready, ren_v1, ren_v2, stall_out, init_busy, err;
  logic [3:0] init_idx, free_cnt;
  logic [4:0] rob_cnt;
`ifdef RENAME_DISPATCH_PERF_EN
  logic [15:0] perf_stall;
`endif
  rename_dispatch_ctrl dut (
    .clock(clock), .reset(reset),
    .dec_v1(dec_v1), .dec_dst1(dec_dst1), .dec_v2(dec_v2), .dec_dst2(dec_dst2),
    .dec_ready(dec_ready), .stall_in(stall_in), .cmt_cnt(cmt_cnt), .cmt_free(cmt_free),
    .flush(flush), .ren_v1(ren_v1), .ren_v2(ren_v2), .stall_out(stall_out),
    .init_busy(init_busy), .init_idx(init_idx), .free_cnt(free_cnt), .rob_cnt(rob_cnt),
`ifdef RENAME_DISPATCH_PERF_EN
    .perf_stall(perf_stall),
`endif
    .err(err)
  );
  always #5 clock = ~clock;
  int vecs = 0, miscompares = 0;
  int m_init, m_idx, m_free, m_rob, m_err, m_rv1, m_rv2, m_st, m_perf;
  typedef struct {
    int v1, d1, v2, d2, st, cc, cf;
    int rdy, rv1, rv2, so, fr, rb;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_init = 1; m_idx = 1; m_free = 3; m_rob = 0; m_err = 0;
    m_rv1 = 0; m_rv2 = 0; m_st = 0; m_perf = 0;
  endtask
  task automatic check_regs();
    chk("init_busy", int'(init_busy), m_init);
    if (m_init != 0) chk("init_idx", int'(init_idx), m_idx);
    chk("free_cnt", int'(free_cnt), m_free);
    chk("rob_cnt", int'(rob_cnt), m_rob);
    chk("ren_v1", int'(ren_v1), m_rv1);
    chk("ren_v2", int'(ren_v2), m_rv2);
    chk("stall_out", int'(stall_out), m_st);
    chk("err", int'(err), m_err);
`ifdef RENAME_DISPATCH_PERF_EN
    chk("perf_stall", int'(perf_stall), m_perf);
`endif
  endtask
  // drive one cycle from posedge+1; checks dec_ready before the edge and all registers after it
  task automatic drive(input int v1, d1, v2, d2, st, cc, cf, fl, output int rdy_seen);
    int need, slots, any, rdy, f, r;
    dec_v1 = 1'(v1); dec_dst1 = 3'(d1); dec_v2 = 1'(v2); dec_dst2 = 3'(d2);
    stall_in = 1'(st); cmt_cnt = 2'(cc); cmt_free = 2'(cf); flush = 1'(fl);
    #3;
    need  = ((v1 != 0 && d1 != 0) ? 1 : 0) + ((v2 != 0 && d2 != 0) ? 1 : 0);
    slots = v1 + v2;
    any   = (v1 + v2) > 0 ? 1 : 0;
    rdy   = (m_init == 0 && st == 0 && need <= m_free && m_rob + slots <= 16) ? 1 : 0;
    rdy_seen = int'(dec_ready);
    chk("dec_ready", rdy_seen, rdy);
    if (m_init == 0 && any != 0 && rdy == 0 && m_perf < 65535) m_perf++;
    if (fl != 0) begin
      m_init = 1; m_idx = 1; m_free = 3; m_rob = 0; m_rv1 = 0; m_rv2 = 0; m_st = 0;
    end else if (m_init != 0) begin
      if (m_idx == 10) m_init = 0; else m_idx++;
    end else begin
      m_rv1 = (rdy != 0 && any != 0) ? v1 : 0;
      m_rv2 = (rdy != 0 && any != 0) ? v2 : 0;
      m_st  = (any != 0 && st == 0 && !(need <= m_free && m_rob + slots <= 16)) ? 1 : 0;
      f = m_free + cf - ((rdy != 0 && any != 0) ? need : 0);
      r = m_rob + ((rdy != 0 && any != 0) ? slots : 0) - cc;
      if (f > 3) begin f = 3; m_err = 1; end
      if (r < 0) begin r = 0; m_err = 1; end
      m_free = f; m_rob = r;
    end
    @(posedge clock); #1;
    flush = 0;
    check_regs();
  endtask
  // ten INIT cycles with commits and valid pairs offered, all of which must be ignored
  task automatic sweep();
    int rs;
    for (int i = 1; i <= 10; i++) begin
      chk("sweep_busy", int'(init_busy), 1);
      chk("sweep_idx", int'(init_idx), i);
      drive(1, 2, 1, 3, 0, 1, 2, 0, rs);
    end
    chk("sweep_done", int'(init_busy), 0);
    chk("sweep_free", int'(free_cnt), 3);
    chk("sweep_rob", int'(rob_cnt), 0);
  endtask
  initial begin
    int rs;
    tbl[0] = '{1,3,1,0,0,0,0, 1,1,1,0,2,2};
    tbl[1] = '{1,1,1,2,0,0,0, 1,1,1,0,0,4};
    tbl[2] = '{1,5,0,0,0,0,0, 0,0,0,1,0,4};
    tbl[3] = '{1,5,0,0,0,1,1, 0,0,0,1,1,3};
    tbl[4] = '{1,1,1,2,0,0,0, 0,0,0,1,1,3};
    tbl[5] = '{1,1,1,2,0,1,1, 0,0,0,1,2,2};
    tbl[6] = '{1,1,1,2,0,0,0, 1,1,1,0,0,4};
    tbl[7] = '{1,0,0,0,1,0,0, 0,0,0,0,0,4};
    tbl[8] = '{0,0,0,0,0,2,2, 1,0,0,0,2,2};
    tbl[9] = '{0,0,0,0,0,2,1, 1,0,0,0,3,0};
    @(posedge clock); #1;
    reset = 0;
    model_reset();
    check_regs();
    sweep();
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].st, tbl[i].cc, tbl[i].cf, 0, rs);
      chk("tbl_ready", rs, tbl[i].rdy);
      chk("tbl_ren_v1", int'(ren_v1), tbl[i].rv1);
      chk("tbl_ren_v2", int'(ren_v2), tbl[i].rv2);
      chk("tbl_stall_out", int'(stall_out), tbl[i].so);
      chk("tbl_free", int'(free_cnt), tbl[i].fr);
      chk("tbl_rob", int'(rob_cnt), tbl[i].rb);
    end
    for (int i = 0; i < 7; i++) drive(1, 0, 1, 0, 0, 0, 0, 0, rs);
    drive(1, 0, 0, 0, 0, 0, 0, 0, rs);
    chk("rob_at_15", int'(rob_cnt), 15);
    drive(1, 0, 1, 0, 0, 0, 0, 0, rs);
    chk("rob15_pair_held", rs, 0);
    chk("rob15_stall_out", int'(stall_out), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, rs);
    chk("rob15_single_fire", rs, 1);
    chk("rob_at_16", int'(rob_cnt), 16);
    drive(1, 0, 1, 0, 0, 2, 0, 0, rs);
    chk("rob16_pair_held", rs, 0);
    chk("rob_after_cmt", int'(rob_cnt), 14);
    drive(1, 0, 1, 0, 0, 0, 0, 0, rs);
    chk("rob14_pair_fire", rs, 1);
    chk("rob_refill", int'(rob_cnt), 16);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 2, 0, 0, rs);
    chk("rob_at_4", int'(rob_cnt), 4);
    drive(1, 1, 0, 0, 0, 2, 0, 1, rs);
    chk("flush_busy", int'(init_busy), 1);
    chk("flush_rob", int'(rob_cnt), 0);
    chk("flush_free", int'(free_cnt), 3);
    chk("flush_ren", int'(ren_v1) + int'(ren_v2), 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, rs);
    chk("init_mid_idx", int'(init_idx), 4);
    drive(0, 0, 0, 0, 0, 0, 0, 1, rs);
    sweep();
    drive(0, 0, 0, 0, 0, 1, 0, 0, rs);
    chk("underflow_rob", int'(rob_cnt), 0);
    chk("underflow_err", int'(err), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, rs);
    sweep();
    chk("err_sticky", int'(err), 1);
    for (int i = 0; i < 600; i++) begin
      int fl;
      fl = ($urandom_range(0, 39) == 0) ? 1 : 0;
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 2), $urandom_range(0, 2), fl, rs);
    end
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    model_reset();
    check_regs();
    chk("reset_clears_err", int'(err), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
